// File: rtl/udp_rx_bank_ctrl_if.sv
// udp_rx_bank_ctrl_if: bundle of receiver, buffer-RAM and reader signals for the ping-pong bank controller
//   rx_wr, rx_data              receiver word strobe and data
//   buf_we, buf_adr, buf_din    registered packet buffer RAM write port, address {bank, word_index}
//   pkt_valid, pkt_bank, pkt_len offered bank towards the reader
//   pkt_done                    reader release pulse
//   busy, drop_cnt              status: burst in progress, saturating discarded-burst count
//   master modport drives the receiver/reader side, slave modport is the controller
interface udp_rx_bank_ctrl_if #(
    parameter int ADR_W = 11,
    parameter int DW    = 32
);
    logic             rx_wr;
    logic [DW-1:0]    rx_data;
    logic             buf_we;
    logic [ADR_W:0]   buf_adr;
    logic [DW-1:0]    buf_din;
    logic             pkt_valid;
    logic             pkt_bank;
    logic [ADR_W:0]   pkt_len;
    logic             pkt_done;
    logic             busy;
    logic [15:0]      drop_cnt;
    modport master (
        output rx_wr, rx_data, pkt_done,
        input  buf_we, buf_adr, buf_din, pkt_valid, pkt_bank, pkt_len, busy, drop_cnt
    );
    modport slave (
        input  rx_wr, rx_data, pkt_done,
        output buf_we, buf_adr, buf_din, pkt_valid, pkt_bank, pkt_len, busy, drop_cnt
    );
endinterface

// File: rtl/udp_rx_bank_ctrl.sv
// udp_rx_bank_ctrl: steers receiver bursts into two packet-buffer banks and hands full banks to the reader
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    udp_rx_bank_ctrl_if.slave: rx_wr/rx_data in, buf_we/buf_adr/buf_din out,
//          pkt_valid/pkt_bank/pkt_len out, pkt_done in, busy/drop_cnt out
module udp_rx_bank_ctrl #(
    parameter int ADR_W = 11,
    parameter int DW    = 32
) (
    input logic               clk,
    input logic               rst_n,
    udp_rx_bank_ctrl_if.slave bus
);
    localparam logic [ADR_W:0] DEPTH = {1'b1, {ADR_W{1'b0}}};
    localparam logic [ADR_W:0] ONE   = {{ADR_W{1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;
    state_t         state, state_nx;
    logic           wr_bank, rd_bank;
    logic [1:0]     full, set_m, clr_m;
    logic [ADR_W:0] len [2];
    logic [ADR_W:0] wcnt, wcnt_nx, adr_nx;
    logic           we_nx, close, drop_inc, release_bank;
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        we_nx    = 1'b0;
        adr_nx   = bus.buf_adr;
        close    = 1'b0;
        drop_inc = 1'b0;
        case (state)
            IDLE: if (bus.rx_wr) begin
                if (!full[wr_bank]) begin
                    we_nx    = 1'b1;
                    adr_nx   = {wr_bank, {ADR_W{1'b0}}};
                    wcnt_nx  = ONE;
                    state_nx = FILL;
                end else begin
                    drop_inc = 1'b1;
                    state_nx = DROP;
                end
            end
            FILL: if (!bus.rx_wr) begin
                close    = 1'b1;
                state_nx = IDLE;
            end else if (wcnt < DEPTH) begin
                we_nx   = 1'b1;
                adr_nx  = {wr_bank, wcnt[ADR_W-1:0]};
                wcnt_nx = wcnt + ONE;
            end
            DROP:    state_nx = bus.rx_wr ? DROP : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // writer only closes an empty bank and reader only releases a full one, so the masks never collide
    assign release_bank = bus.pkt_done & full[rd_bank];
    assign set_m = {close & wr_bank, close & ~wr_bank};
    assign clr_m = {release_bank & rd_bank, release_bank & ~rd_bank};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wcnt         <= '0;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            full         <= 2'b00;
            len[0]       <= '0;
            len[1]       <= '0;
            bus.buf_we   <= 1'b0;
            bus.buf_adr  <= '0;
            bus.buf_din  <= '0;
            bus.drop_cnt <= '0;
        end else begin
            state      <= state_nx;
            wcnt       <= wcnt_nx;
            bus.buf_we <= we_nx;
            bus.buf_adr <= adr_nx;
            if (we_nx) bus.buf_din <= bus.rx_data;
            if (close) begin
                len[wr_bank] <= wcnt;
                wr_bank      <= ~wr_bank;
            end
            full <= (full | set_m) & ~clr_m;
            if (release_bank) rd_bank <= ~rd_bank;
            if (drop_inc && bus.drop_cnt != 16'hFFFF) bus.drop_cnt <= bus.drop_cnt + 16'd1;
        end
    end
    assign bus.pkt_valid = full[rd_bank];
    assign bus.pkt_bank  = rd_bank;
    assign bus.pkt_len   = len[rd_bank];
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_udp_rx_bank_ctrl.sv
// tb_udp_rx_bank_ctrl: directed and randomized checks of the bank controller against a packet-queue model
module tb_udp_rx_bank_ctrl;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int DEPTH = 2048;
    typedef logic [AW+DW:0] wr_t;
    typedef struct { logic bank; int len; } pkt_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    pkt_t pq[$];
    wr_t eq[$];
    wr_t exp_w;
    logic wr_b = 1'b0;
    logic rd_b = 1'b0;
    int drops = 0;
    udp_rx_bank_ctrl_if #(.ADR_W(AW), .DW(DW)) bus ();
    udp_rx_bank_ctrl #(.ADR_W(AW), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // write scoreboard: every RAM write must match the next expected {adr, data}
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.busy) busy_cnt++;
            if (bus.buf_we) begin
                wr_cnt++;
                n_checks++;
                if (eq.size() == 0) begin
                    n_fail++;
                    $display("FAIL write_unexpected adr=%h din=%h required no write", bus.buf_adr, bus.buf_din);
                end else begin
                    exp_w = eq.pop_front();
                    if ({bus.buf_adr, bus.buf_din} !== exp_w) begin
                        n_fail++;
                        $display("FAIL write adr=%h din=%h required adr=%h din=%h", bus.buf_adr, bus.buf_din,
                                 exp_w[AW+DW:DW], exp_w[DW-1:0]);
                    end
                end
            end
        end
    end
    task automatic model_clear();
        pq.delete();
        eq.delete();
        wr_b = 1'b0;
        rd_b = 1'b0;
        drops = 0;
    endtask
    task automatic apply_reset();
        bus.rx_wr = 1'b0;
        bus.pkt_done = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask
    // entered and left #1 after a rising edge; the next call starts one cycle after rx_wr drops
    task automatic drive_burst(input int n, input bit done_at_close, input bit seq);
        bit acc;
        logic b;
        acc = pq.size() < 2;
        b = wr_b;
        if (!acc && drops < 65535) drops++;
        for (int i = 0; i < n; i++) begin
            bus.rx_wr = 1'b1;
            bus.rx_data = seq ? 32'h11 * (i + 1) : $urandom;
            if (acc && i < DEPTH) eq.push_back({b, AW'(i), bus.rx_data});
            @(posedge clk); #1;
        end
        bus.rx_wr = 1'b0;
        if (done_at_close) bus.pkt_done = 1'b1;
        @(posedge clk); #1;
        bus.pkt_done = 1'b0;
        if (done_at_close && pq.size() > 0) begin
            void'(pq.pop_front());
            rd_b = ~rd_b;
        end
        if (acc) begin
            pq.push_back('{b, (n > DEPTH) ? DEPTH : n});
            wr_b = ~wr_b;
        end
    endtask
    task automatic do_done();
        bus.pkt_done = 1'b1;
        @(posedge clk); #1;
        bus.pkt_done = 1'b0;
        if (pq.size() > 0) begin
            void'(pq.pop_front());
            rd_b = ~rd_b;
        end
    endtask
    task automatic test_reset();
        bus.rx_wr = 1'b0;
        bus.rx_data = '0;
        bus.pkt_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (bus.buf_we !== 1'b0 || bus.buf_adr !== '0 || bus.buf_din !== '0) begin
            n_fail++;
            $display("FAIL reset_buf we=%b adr=%h din=%h required 0", bus.buf_we, bus.buf_adr, bus.buf_din);
        end
        if (bus.pkt_valid !== 1'b0 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== '0) begin
            n_fail++;
            $display("FAIL reset_pkt valid=%b bank=%b len=%0d required 0", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", bus.busy); end
        if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d required 0", bus.drop_cnt); end
        rst_n = 1'b1;
        model_clear();
        @(posedge clk); #1;
    endtask
    task automatic test_basic();
        int w0;
        w0 = wr_cnt;
        drive_burst(4, 0, 1);
        n_checks += 3;
        if (wr_cnt - w0 !== 4 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL basic_writes got %0d pending %0d required 4 pending 0", wr_cnt - w0, eq.size());
        end
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pkt valid=%b bank=%b required 1/0", bus.pkt_valid, bus.pkt_bank);
        end
        if (bus.pkt_len !== 12'd4) begin n_fail++; $display("FAIL basic_len got %0d required 4", bus.pkt_len); end
        do_done();
        n_checks++;
        if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL basic_release valid=%b required 0", bus.pkt_valid); end
    endtask
    task automatic test_two_bursts();
        apply_reset();
        drive_burst(5, 0, 1);
        drive_burst(3, 0, 1);
        n_checks += 2;
        if (eq.size() != 0) begin n_fail++; $display("FAIL two_writes pending %0d required 0", eq.size()); end
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== 12'd5) begin
            n_fail++;
            $display("FAIL two_first valid=%b bank=%b len=%0d required 1/0/5", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
    endtask
    task automatic test_drop();
        int w0;
        w0 = wr_cnt;
        busy_cnt = 0;
        drive_burst(7, 0, 0);
        n_checks += 4;
        if (wr_cnt !== w0) begin n_fail++; $display("FAIL drop_writes got %0d required 0", wr_cnt - w0); end
        if (bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d required 1", bus.drop_cnt); end
        if (busy_cnt !== 7) begin n_fail++; $display("FAIL drop_busy got %0d cycles required 7", busy_cnt); end
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== 12'd5) begin
            n_fail++;
            $display("FAIL drop_len0 valid=%b bank=%b len=%0d required 1/0/5", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        do_done();
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b1 || bus.pkt_len !== 12'd3) begin
            n_fail++;
            $display("FAIL drop_len1 valid=%b bank=%b len=%0d required 1/1/3", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        do_done();
        n_checks++;
        if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL drop_empty valid=%b required 0", bus.pkt_valid); end
    endtask
    task automatic test_oversize();
        int w0;
        w0 = wr_cnt;
        drive_burst(2100, 0, 0);
        n_checks += 3;
        if (wr_cnt - w0 !== 2048 || eq.size() != 0) begin
            n_fail++;
            $display("FAIL over_writes got %0d pending %0d required 2048 pending 0", wr_cnt - w0, eq.size());
        end
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== 12'd2048) begin
            n_fail++;
            $display("FAIL over_pkt valid=%b bank=%b len=%0d required 1/0/2048", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        if (bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL over_drop got %0d required 1", bus.drop_cnt); end
        do_done();
    endtask
    task automatic test_back_to_back();
        drive_burst(4, 0, 0);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b1 || bus.pkt_len !== 12'd4) begin
            n_fail++;
            $display("FAIL b2b_first valid=%b bank=%b len=%0d required 1/1/4", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        drive_burst(6, 1, 0);
        n_checks += 2;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== 12'd6) begin
            n_fail++;
            $display("FAIL b2b_same_cycle valid=%b bank=%b len=%0d required 1/0/6", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        if (eq.size() != 0) begin n_fail++; $display("FAIL b2b_writes pending %0d required 0", eq.size()); end
        do_done();
        n_checks++;
        if (bus.pkt_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty valid=%b required 0", bus.pkt_valid); end
        do_done();
        n_checks += 2;
        if (bus.pkt_valid !== 1'b0 || bus.pkt_bank !== 1'b1) begin
            n_fail++;
            $display("FAIL spurious_done valid=%b bank=%b required 0/1", bus.pkt_valid, bus.pkt_bank);
        end
        if (bus.drop_cnt !== 16'd1) begin n_fail++; $display("FAIL spurious_drop got %0d required 1", bus.drop_cnt); end
        drive_burst(3, 0, 0);
        n_checks++;
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b1 || bus.pkt_len !== 12'd3) begin
            n_fail++;
            $display("FAIL spurious_next valid=%b bank=%b len=%0d required 1/1/3", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        do_done();
    endtask
    task automatic test_mid_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            bus.rx_wr = 1'b1;
            bus.rx_data = $urandom;
            eq.push_back({1'b0, AW'(i), bus.rx_data});
            if (i < 9) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (bus.buf_we !== 1'b0 || bus.buf_adr !== '0 || bus.buf_din !== '0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_buf we=%b adr=%h din=%h busy=%b required 0", bus.buf_we, bus.buf_adr, bus.buf_din, bus.busy);
        end
        if (bus.pkt_valid !== 1'b0 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== '0) begin
            n_fail++;
            $display("FAIL midrst_pkt valid=%b bank=%b len=%0d required 0", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
        if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_drop got %0d required 0", bus.drop_cnt); end
        bus.rx_wr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        drive_burst(2, 0, 1);
        n_checks += 2;
        if (eq.size() != 0) begin n_fail++; $display("FAIL midrst_writes pending %0d required 0", eq.size()); end
        if (bus.pkt_valid !== 1'b1 || bus.pkt_bank !== 1'b0 || bus.pkt_len !== 12'd2) begin
            n_fail++;
            $display("FAIL midrst_pkt2 valid=%b bank=%b len=%0d required 1/0/2", bus.pkt_valid, bus.pkt_bank, bus.pkt_len);
        end
    endtask
    task automatic test_random();
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) do_done();
            drive_burst($urandom_range(1, 12), $urandom_range(0, 3) == 0, 0);
            n_checks += 3;
            if (eq.size() != 0) begin n_fail++; $display("FAIL rand_writes it=%0d pending %0d required 0", it, eq.size()); end
            if (bus.pkt_valid !== (pq.size() > 0) || bus.pkt_bank !== (pq.size() > 0 ? pq[0].bank : rd_b)) begin
                n_fail++;
                $display("FAIL rand_pkt it=%0d valid=%b bank=%b required %0d/%b", it, bus.pkt_valid, bus.pkt_bank,
                         pq.size() > 0, pq.size() > 0 ? pq[0].bank : rd_b);
            end
            if (bus.drop_cnt !== 16'(drops)) begin
                n_fail++;
                $display("FAIL rand_drop it=%0d got %0d required %0d", it, bus.drop_cnt, drops);
            end
            if (pq.size() > 0) begin
                n_checks++;
                if (bus.pkt_len !== 12'(pq[0].len)) begin
                    n_fail++;
                    $display("FAIL rand_len it=%0d got %0d required %0d", it, bus.pkt_len, pq[0].len);
                end
            end
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_two_bursts();
        test_drop();
        test_oversize();
        test_back_to_back();
        test_mid_reset();
        test_random();
        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
